// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM states and the bus mode constants
// common to the SPI master and slave blocks.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    DONE
  } spi_state_e;

  // Mode 0: sclk idles low, miso is sampled on the leading (rising) edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// Divider producing a one-cycle terminal-count enable every CLK_DIV clk cycles
// while enabled; the count is held at zero whenever disabled.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = en && (cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master (mode 0): one DATA_WIDTH-bit frame per request, MSB first,
// with every output registered on the rising edge of clk.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  spi_state_e state, state_next;

  logic [DATA_WIDTH-1:0] tx_shift, tx_shift_next;
  logic [DATA_WIDTH-1:0] rx_shift, rx_shift_next;
  logic [DATA_WIDTH-1:0] rx_data_next;
  logic [BW-1:0]         bit_cnt, bit_cnt_next;
  logic                  sclk_next, mosi_next, cs_next, tx_ready_next, rx_valid_next;
  logic                  div_en, tick, sample_edge;

  assign div_en = (state == SETUP) || (state == XFER);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk (clk),
    .rst (rst),
    .en  (div_en),
    .tick(tick)
  );

  // The mode constants pick which sclk edge samples miso; the other edge shifts mosi.
  assign sample_edge = (sclk == CPOL) ^ CPHA;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      sclk     <= CPOL;
      mosi     <= 1'b0;
      cs       <= 1'b1;
      tx_ready <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      state    <= state_next;
      tx_shift <= tx_shift_next;
      rx_shift <= rx_shift_next;
      bit_cnt  <= bit_cnt_next;
      sclk     <= sclk_next;
      mosi     <= mosi_next;
      cs       <= cs_next;
      tx_ready <= tx_ready_next;
      rx_valid <= rx_valid_next;
      rx_data  <= rx_data_next;
    end
  end

  always_comb begin
    state_next    = state;
    tx_shift_next = tx_shift;
    rx_shift_next = rx_shift;
    bit_cnt_next  = bit_cnt;
    sclk_next     = sclk;
    mosi_next     = mosi;
    rx_valid_next = 1'b0;
    rx_data_next  = rx_data;

    case (state)
      IDLE: begin
        sclk_next = CPOL;
        mosi_next = 1'b0;
        if (tx_valid) begin
          state_next    = SETUP;
          tx_shift_next = tx_data;
          mosi_next     = tx_data[DATA_WIDTH-1];
          bit_cnt_next  = '0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_next = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          sclk_next = ~sclk;
          if (sample_edge) begin
            rx_shift_next = {rx_shift[DATA_WIDTH-2:0], miso};
          end else if (bit_cnt == LAST_BIT) begin
            state_next    = DONE;
            sclk_next     = CPOL;
            mosi_next     = 1'b0;
            rx_valid_next = 1'b1;
            rx_data_next  = rx_shift;
          end else begin
            // Rotating keeps every shift bit live; only the MSB is ever driven out.
            bit_cnt_next  = bit_cnt + 1'b1;
            tx_shift_next = {tx_shift[DATA_WIDTH-2:0], tx_shift[DATA_WIDTH-1]};
            mosi_next     = tx_shift[DATA_WIDTH-2];
          end
        end
      end
      DONE: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    cs_next       = (state_next == IDLE) || (state_next == DONE);
    tx_ready_next = (state_next == IDLE);
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: a CLK_DIV=4 and a CLK_DIV=1 instance,
// table and random frames checked against a frame-level reference model.
module tb_spi_master;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slave;
    bit         loop;
    logic [7:0] exp_rx;
  } vec_t;

  logic            clk = 1'b0;
  logic [1:0]      rst_w = 2'b11;
  logic [1:0][7:0] tx_data_w;
  logic [1:0]      tx_valid_w;
  wire  [1:0]      tx_ready_w;
  wire  [1:0][7:0] rx_data_w;
  wire  [1:0]      rx_valid_w;
  wire  [1:0]      sclk_w;
  wire  [1:0]      mosi_w;
  wire  [1:0]      miso_w;
  wire  [1:0]      cs_w;

  logic [1:0]      loop_w;
  logic [1:0][7:0] slave_word;
  logic [1:0]      slave_bit = 2'b00;

  int total = 0;
  int bad   = 0;

  int         cs_low_run[2], last_cs_low[2], cs_high_run[2], last_cs_high[2];
  int         rise_cnt[2], fall_cnt[2], toggles[2], rv_count[2];
  logic [1:0][7:0] mosi_seen;
  logic [1:0] prev_cs = 2'b11;
  logic [1:0] prev_sclk = 2'b00;
  logic [1:0] prev_rv = 2'b00;

  vec_t vecs[4];

  always #5 clk = ~clk;

  assign miso_w[0] = loop_w[0] ? mosi_w[0] : slave_bit[0];
  assign miso_w[1] = loop_w[1] ? mosi_w[1] : slave_bit[1];

  spi_master #(.CLK_DIV(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst_w[0]), .tx_data(tx_data_w[0]), .tx_valid(tx_valid_w[0]),
    .tx_ready(tx_ready_w[0]), .rx_data(rx_data_w[0]), .rx_valid(rx_valid_w[0]),
    .sclk(sclk_w[0]), .mosi(mosi_w[0]), .miso(miso_w[0]), .cs(cs_w[0])
  );

  spi_master #(.CLK_DIV(1), .DATA_WIDTH(8)) dut_div1 (
    .clk(clk), .rst(rst_w[1]), .tx_data(tx_data_w[1]), .tx_valid(tx_valid_w[1]),
    .tx_ready(tx_ready_w[1]), .rx_data(rx_data_w[1]), .rx_valid(rx_valid_w[1]),
    .sclk(sclk_w[1]), .mosi(mosi_w[1]), .miso(miso_w[1]), .cs(cs_w[1])
  );

  function automatic int clk_div_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // Reference model: a frame lasts (2*8+1)*CLK_DIV cs-low cycles, mosi carries tx MSB first,
  // and rx is whatever the far end drove (tx itself in loopback).
  function automatic logic [7:0] model_rx(input logic [7:0] tx, input logic [7:0] slave, input bit loop);
    return loop ? tx : slave;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic monitorStep(input int d);
    if (cs_w[d] === 1'b0) begin
      if (prev_cs[d]) begin
        cs_low_run[d]   = 0;
        rise_cnt[d]     = 0;
        toggles[d]      = 0;
        mosi_seen[d]    = '0;
        last_cs_high[d] = cs_high_run[d];
      end else if (sclk_w[d] !== prev_sclk[d]) begin
        toggles[d]++;
      end
      cs_low_run[d]++;
      if (sclk_w[d] && !prev_sclk[d]) begin
        rise_cnt[d]++;
        mosi_seen[d] = {mosi_seen[d][6:0], mosi_w[d]};
      end
      if (!sclk_w[d] && prev_sclk[d]) fall_cnt[d]++;
    end else begin
      if (!prev_cs[d]) begin
        last_cs_low[d] = cs_low_run[d];
        cs_high_run[d] = 0;
      end
      cs_high_run[d]++;
      fall_cnt[d] = 0;
      if (cs_w[d] === 1'b1) begin
        checkOutput($sformatf("dut%0d mosi while cs high", d), mosi_w[d], 0);
        checkOutput($sformatf("dut%0d sclk while cs high", d), sclk_w[d], 0);
      end
    end
    if (prev_rv[d]) checkOutput($sformatf("dut%0d rx_valid single pulse", d), rx_valid_w[d], 0);
    if (rx_valid_w[d] === 1'b1) rv_count[d]++;
    slave_bit[d] = (fall_cnt[d] < 8) ? slave_word[d][7 - fall_cnt[d]] : 1'b0;
    prev_cs[d]   = (cs_w[d] === 1'b0) ? 1'b0 : 1'b1;
    prev_sclk[d] = (sclk_w[d] === 1'b1);
    prev_rv[d]   = (rx_valid_w[d] === 1'b1);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) monitorStep(d);
  end

  task automatic waitReady(input int d, input string name);
    int k = 0;
    @(negedge clk);
    while (!tx_ready_w[d] && k < 300) begin
      @(negedge clk);
      k++;
    end
    checkOutput({name, " tx_ready before request"}, tx_ready_w[d], 1);
  endtask

  task automatic waitRxValid(input int d, input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rx_valid_w[d] && k < 2000);
    checkOutput({name, " rx_valid seen"}, rx_valid_w[d], 1);
  endtask

  // One full frame on dut d, then every frame-level property is compared to the model.
  task automatic applyStimulus(input int d, input logic [7:0] tx, input logic [7:0] slave,
                               input bit loop, input logic [7:0] exp_rx, input string name);
    int rv_before;
    slave_word[d] = slave;
    loop_w[d]     = loop;
    waitReady(d, name);
    rv_before     = rv_count[d];
    tx_data_w[d]  = tx;
    tx_valid_w[d] = 1'b1;
    @(posedge clk);
    #1 tx_valid_w[d] = 1'b0;
    waitRxValid(d, name);
    @(negedge clk);
    checkOutput({name, " rx_data"}, rx_data_w[d], exp_rx);
    checkOutput({name, " mosi bits"}, mosi_seen[d], tx);
    checkOutput({name, " cs low cycles"}, last_cs_low[d], (2 * 8 + 1) * clk_div_of(d));
    checkOutput({name, " sclk rises"}, rise_cnt[d], 8);
    checkOutput({name, " sclk toggles"}, toggles[d], 15);
    checkOutput({name, " rx_valid pulses"}, rv_count[d] - rv_before, 1);
    checkOutput({name, " rx_valid low after DONE"}, rx_valid_w[d], 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int k;
    int rv_before;
    logic [7:0] tx, slave;
    bit loop;
    int d;

    tx_valid_w = '0;
    tx_data_w  = '0;
    loop_w     = '0;
    slave_word = '0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("reset dut%0d cs", i), cs_w[i], 1);
      checkOutput($sformatf("reset dut%0d sclk", i), sclk_w[i], 0);
      checkOutput($sformatf("reset dut%0d mosi", i), mosi_w[i], 0);
      checkOutput($sformatf("reset dut%0d tx_ready", i), tx_ready_w[i], 1);
      checkOutput($sformatf("reset dut%0d rx_valid", i), rx_valid_w[i], 0);
      checkOutput($sformatf("reset dut%0d rx_data", i), rx_data_w[i], 0);
    end
    rst_w = 2'b00;

    vecs[0] = '{8'hA5, 8'h00, 1'b1, 8'hA5};
    vecs[1] = '{8'hFF, 8'h3C, 1'b0, 8'h3C};
    vecs[2] = '{8'h00, 8'hFF, 1'b0, 8'hFF};
    vecs[3] = '{8'h81, 8'h7E, 1'b0, 8'h7E};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, vecs[i].tx, vecs[i].slave, vecs[i].loop, vecs[i].exp_rx, $sformatf("vec%0d", i));
    end

    applyStimulus(1, 8'h5A, 8'h00, 1'b1, 8'h5A, "div1 loop 5A");

    for (int i = 0; i < 10; i++) begin
      d     = int'($urandom_range(0, 1));
      tx    = 8'($urandom_range(0, 255));
      slave = 8'($urandom_range(0, 255));
      loop  = 1'($urandom_range(0, 1));
      applyStimulus(d, tx, slave, loop, model_rx(tx, slave, loop), $sformatf("rand%0d", i));
    end

    // Back-to-back: tx_valid held, 0x01 then 0x80 in loopback.
    loop_w[0] = 1'b1;
    waitReady(0, "b2b");
    tx_data_w[0]  = 8'h01;
    tx_valid_w[0] = 1'b1;
    @(posedge clk);
    #1 tx_data_w[0] = 8'h80;
    waitRxValid(0, "b2b first");
    checkOutput("b2b first rx_data", rx_data_w[0], 8'h01);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k >= 2) tx_valid_w[0] = 1'b0;
    end while (!rx_valid_w[0] && k < 300);
    checkOutput("b2b rx_valid spacing", k, 70);
    checkOutput("b2b second rx_data", rx_data_w[0], 8'h80);
    checkOutput("b2b cs high between frames", last_cs_high[0], 2);
    tx_valid_w[0] = 1'b0;

    // A request during an active frame is ignored.
    waitReady(0, "ignore");
    rv_before     = rv_count[0];
    tx_data_w[0]  = 8'hC3;
    tx_valid_w[0] = 1'b1;
    @(posedge clk);
    #1 tx_valid_w[0] = 1'b0;
    repeat (20) @(negedge clk);
    tx_data_w[0]  = 8'h11;
    tx_valid_w[0] = 1'b1;
    @(negedge clk);
    tx_valid_w[0] = 1'b0;
    waitRxValid(0, "ignore");
    checkOutput("ignore rx_data", rx_data_w[0], 8'hC3);
    @(negedge clk);
    checkOutput("ignore mosi bits", mosi_seen[0], 8'hC3);
    repeat (100) @(negedge clk);
    checkOutput("ignore single frame", rv_count[0] - rv_before, 1);
    checkOutput("ignore cs idle", cs_w[0], 1);

    // Reset 20 cycles into a frame aborts it; rx_data held until then.
    waitReady(0, "abort");
    tx_data_w[0]  = 8'hA5;
    tx_valid_w[0] = 1'b1;
    @(posedge clk);
    #1 tx_valid_w[0] = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("abort rx_data held mid-frame", rx_data_w[0], 8'hC3);
    checkOutput("abort cs low mid-frame", cs_w[0], 0);
    rv_before = rv_count[0];
    rst_w[0]  = 1'b1;
    tx_valid_w[0] = 1'b1;
    @(negedge clk);
    checkOutput("abort cs", cs_w[0], 1);
    checkOutput("abort sclk", sclk_w[0], 0);
    checkOutput("abort tx_ready", tx_ready_w[0], 1);
    checkOutput("abort rx_valid", rx_valid_w[0], 0);
    checkOutput("abort rx_data", rx_data_w[0], 0);
    tx_valid_w[0] = 1'b0;
    rst_w[0]      = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("abort no rx_valid", rv_count[0] - rv_before, 0);
    checkOutput("abort idle after", cs_w[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter SHALL be CLK_DIV, default 4, the number of clk cycles per sclk half-period; legal values are 1..255.
REQ-002 Parameter SHALL be DATA_WIDTH, default 8, the bits per frame, shifted MSB first.
REQ-003 Port SHALL be clk, input, 1, the single system clock; every output is registered on its rising edge.
REQ-004 Port SHALL be rst, input, 1; reset is synchronous and active-high.
REQ-005 Port SHALL be tx_data, input, DATA_WIDTH, the frame to transmit.
REQ-006 Port SHALL be tx_valid, input, 1, which requests a frame.
REQ-007 Port SHALL be tx_ready, output, 1; the master is idle and accepts a frame.
REQ-008 Port SHALL be rx_data, output, DATA_WIDTH, the frame received on miso.
REQ-009 Port SHALL be rx_valid, output, 1, a one-cycle pulse that marks rx_data as new.
REQ-010 Port SHALL be sclk, output, 1, the serial clock (mode 0, CPOL=0).
REQ-011 Port SHALL be mosi, output, 1, the serial data out.
REQ-012 Port SHALL be miso, input, 1, the serial data in.
REQ-013 Port SHALL be cs, output, 1, the active-low chip select.

Function
REQ-014 The state machine SHALL have states IDLE, SETUP, XFER and DONE.
REQ-015 IDLE: tx_ready=1, cs=1, sclk=0.
- tx_valid && tx_ready at edge N loads tx_data into the shift register.
- cs=0, tx_ready=0 and mosi=tx_data[MSB] from cycle N+1.
- Next state is SETUP.
REQ-016 SETUP SHALL last exactly CLK_DIV cycles with sclk=0, then enter XFER.
REQ-017 XFER SHALL use a divider counter 0..CLK_DIV-1.
- sclk toggles on each terminal count.
- Each bit lasts 2*CLK_DIV cycles.
REQ-018 On each sclk rise, miso SHALL be shifted into the rx shift register (LSB in).
REQ-019 On each sclk fall, mosi SHALL advance to the next bit.
- The final (DATA_WIDTH-th) fall does not advance mosi; it transitions to DONE.
REQ-020 DONE SHALL last 1 cycle with cs=1 and sclk=0.
- rx_data is loaded and rx_valid=1 in this cycle.
- Next state is IDLE.
REQ-021 cs low time SHALL be exactly (2*DATA_WIDTH+1)*CLK_DIV cycles (68 at defaults).
REQ-022 tx_valid SHALL be ignored while tx_ready=0.
- No queuing; tx_data is sampled only at acceptance.
REQ-023 Back-to-back frames: with tx_valid held high, cs SHALL stay high for exactly 2 cycles between frames (DONE plus IDLE-accept).
REQ-024 rx_data SHALL hold its value until the next DONE.
REQ-025 rx_valid SHALL never be high for two consecutive cycles.
REQ-026 mosi SHALL be 0 whenever cs=1.
REQ-027 sclk SHALL be 0 whenever cs=1, and it toggles only in XFER.
REQ-028 CLK_DIV=1: sclk SHALL toggle every cycle and the frame still obeys REQ-021.

Reset
REQ-029 rst SHALL force state=IDLE and the following output values:
- cs=1, sclk=0, mosi=0, tx_ready=1, rx_valid=0, rx_data=0.
- Divider and bit counters=0.
REQ-030 rst asserted mid-frame SHALL abort the frame.
- cs returns high at the next edge.
- rx_valid is not pulsed.
- rx_data is cleared.
REQ-031 rst SHALL take priority over tx_valid in the same cycle.

Structure
REQ-032 Package spi_pkg SHALL hold the state enum (IDLE, SETUP, XFER, DONE) and the CPOL/CPHA mode constants shared with the SPI slave block.
REQ-033 Sub-module spi_clk_div SHALL generate the CLK_DIV terminal-count enable.
- The main block instantiates it once; no generated clocks.
- sclk is a registered data output.

Verification
REQ-034 Loopback (miso tied to mosi), tx_data=0xA5, defaults -> rx_data=0xA5, rx_valid one pulse, cs low 68 cycles, 8 sclk rises.
REQ-035 miso driven from a model returning 0x3C, tx 0xFF -> mosi high for all bits, rx_data=0x3C.
REQ-036 tx_valid held high, frames 0x01 then 0x80 -> two frames, cs high exactly 2 cycles between them, rx_valid pulses 70 cycles apart.
REQ-037 rst asserted 20 cycles after acceptance -> cs=1, sclk=0, tx_ready=1 next cycle, no rx_valid, rx_data=0.
REQ-038 CLK_DIV=1, tx 0x5A loopback -> sclk toggles every cycle in XFER, cs low 17 cycles, rx_data=0x5A.
REQ-039 tx_valid pulsed with 0x11 during an active frame -> ignored; the current frame completes unchanged.
